mem_controller_storeless: RTL
=============================

# mem_controller_storeless

Load-only memory controller for the handshake dataflow library, for arrays the kernel reads but never writes. It arbitrates NUM_LOADS elastic load-address channels onto the read port of a dual-port BRAM with one-cycle read latency, and returns each word to the requesting port through a one-entry response register. A start/end control FSM brackets the memory's lifetime in the circuit. The BRAM write port is tied off.

## Interface
Parameters:
- NUM_LOADS, 1: number of load ports.
- DATA_TYPE, 32: data word width.
- ADDR_TYPE, 32: address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low. Sampled on the rising edge of clk; the block is in reset while rst=0.
- memStart_valid  in  1 / memStart_ready  out  1  start control channel.
- memEnd_valid  out  1 / memEnd_ready  in  1  end control channel.
- ctrlEnd_valid  in  1 / ctrlEnd_ready  out  1  "no more requests" channel.
- ldAddr  in  NUM_LOADS*ADDR_TYPE  load addresses; port i is bits [i*ADDR_TYPE +: ADDR_TYPE].
- ldAddr_valid  in  NUM_LOADS / ldAddr_ready  out  NUM_LOADS  per-port address handshake.
- ldData  out  NUM_LOADS*DATA_TYPE  returned words; port i is bits [i*DATA_TYPE +: DATA_TYPE].
- ldData_valid  out  NUM_LOADS / ldData_ready  in  NUM_LOADS  per-port data handshake.
- loadData  in  DATA_TYPE  BRAM read data, valid one cycle after loadEn.
- loadEn  out  1 / loadAddr  out  ADDR_TYPE  BRAM read enable and address.
- storeEn  out  1 / storeAddr  out  ADDR_TYPE / storeData  out  DATA_TYPE  BRAM write port, constant 0.

## Operation
- Each port i has a slot state: EMPTY, PEND (read issued, data on loadData this cycle), or FULL (word held in ldData[i]).
- ldData_valid[i] is 1 exactly when slot i is FULL.
- Eligibility: port i is eligible when ldAddr_valid[i]=1 and either slot i is EMPTY, or slot i is FULL and ldData_ready[i]=1. A slot in PEND is never eligible.
- Arbitration is fixed priority: the lowest eligible index wins. At most one grant per cycle.
- ldAddr_ready is combinational and one-hot or zero; the grant g gets ldAddr_ready[g]=1.
- On a grant, loadEn=1 and loadAddr=ldAddr[g]. With no grant, loadEn=0 and loadAddr=0.
- Slot transitions:
  - granted slot → PEND.
  - PEND → FULL; ldData[i] captures loadData.
  - FULL with ldData_ready=1 and no new grant → EMPTY.
  - FULL drained and granted in the same cycle → PEND.
- allDone is 1 when every slot is EMPTY and ldAddr_valid is all zero.
- Control FSM:
  - IDLE: memStart_ready=1. A memStart handshake moves to RUN.
  - RUN: ctrlEnd_ready=allDone. A ctrlEnd handshake moves to END.
  - END: memEnd_valid=1. memEnd_ready=1 moves to IDLE.
- Loads are served in every FSM state; the FSM gates only the control channels.

## Timing
- Reset values:
  - FSM state is IDLE, so memStart_ready=1.
  - memEnd_valid=0, ctrlEnd_ready=0.
  - All slots are EMPTY, so ldData_valid=0 and ldData=0.
  - loadEn=0 and ldAddr_ready=0 while rst=0.
  - storeEn, storeAddr and storeData are always 0.
- Reset mid-operation: PEND and FULL contents are discarded and no ldData_valid is produced for them. The FSM returns to IDLE.
- Latency: an address accepted in cycle t gives loadEn in cycle t and ldData_valid[i]=1 from cycle t+2 until consumed.
- Throughput:
  - one grant per cycle across all ports;
  - at most one grant every 2 cycles per port, provided consumers hold ldData_ready=1.
- Backpressure: with ldData_ready[i]=0 and slot i FULL, port i is stalled. ldData[i] and ldData_valid[i] hold stable until the handshake.
- Simultaneous events:
  - A drain and a new grant on the same port in one cycle are legal.
  - A ctrlEnd handshake and a memStart arriving in the same cycle: memStart is ignored outside IDLE.
- Address and data slices for all NUM_LOADS ports are exact; there is no width conversion.

## Test plan
- Reset: hold rst=0 for 3 cycles with ldAddr_valid=all ones. Required: loadEn=0, ldAddr_ready=0, ldData_valid=0, memStart_ready=1. After release, the first grant goes to port 0.
- Single load, NUM_LOADS=2: port 1 sends addr 0x10; the BRAM model returns 0xCAFE one cycle after loadEn. Required: loadEn=1 and loadAddr=0x10 in cycle t; ldData_valid[1]=1 with 0xCAFE in cycle t+2.
- Contention: both ports valid every cycle, ldData_ready=11. Required: grants alternate 0,1,0,1. A port is never granted while its slot is PEND. Data returns in order per port.
- Backpressure: port 0 ldData_ready=0 for 5 cycles while its slot is FULL with 0x55. Required: ldAddr_ready[0]=0 and ldData[0] stable at 0x55. Port 1 is still served. Raising ready gives a drain plus a new grant in the same cycle.
- Control FSM: memStart handshake, then 3 loads, with ctrlEnd_valid asserted early. Required: ctrlEnd_ready stays 0 until all slots are EMPTY. memEnd_valid rises the cycle after the ctrlEnd handshake and clears after memEnd_ready, returning to IDLE.
- Reset mid-flight: assert rst=0 while a slot is PEND. Required: no ldData_valid after release, and all slots EMPTY.

Source files
------------

// File: rtl/mem_controller_storeless.sv
// mem_controller_storeless: load-only BRAM controller.
// Arbitrates NUM_LOADS elastic load-address channels (fixed priority, lowest
// index wins) onto a one-cycle-latency BRAM read port and returns each word
// through a one-entry response register per port. A start/end FSM brackets
// the memory's lifetime; the BRAM write port is tied off.
module mem_controller_storeless #(
  parameter int NUM_LOADS = 1,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           memStart_valid,
  output logic                           memStart_ready,
  output logic                           memEnd_valid,
  input  logic                           memEnd_ready,
  input  logic                           ctrlEnd_valid,
  output logic                           ctrlEnd_ready,
  input  logic [NUM_LOADS*ADDR_TYPE-1:0] ldAddr,
  input  logic [NUM_LOADS-1:0]           ldAddr_valid,
  output logic [NUM_LOADS-1:0]           ldAddr_ready,
  output logic [NUM_LOADS*DATA_TYPE-1:0] ldData,
  output logic [NUM_LOADS-1:0]           ldData_valid,
  input  logic [NUM_LOADS-1:0]           ldData_ready,
  input  logic [DATA_TYPE-1:0]           loadData,
  output logic                           loadEn,
  output logic [ADDR_TYPE-1:0]           loadAddr,
  output logic                           storeEn,
  output logic [ADDR_TYPE-1:0]           storeAddr,
  output logic [DATA_TYPE-1:0]           storeData
);

  // Per-port response slot: PEND means the BRAM word is on loadData now.
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_END  = 2'd2
  } ctrl_e;

  slot_e                slot_q [NUM_LOADS];
  slot_e                slot_d [NUM_LOADS];
  logic [DATA_TYPE-1:0] data_q [NUM_LOADS];
  logic [DATA_TYPE-1:0] data_d [NUM_LOADS];

  logic [NUM_LOADS-1:0] elig_s;
  logic [NUM_LOADS-1:0] grant_s;
  logic [ADDR_TYPE-1:0] grant_addr_s;
  logic                 all_empty_s;
  logic                 all_done_s;

  ctrl_e                ctrl_q;
  logic                 start_rdy_q;
  logic                 end_vld_q;
  logic                 run_q;

  // A port may request when its slot is free now or is being drained this cycle.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      if (ldAddr_valid[i] &&
          ((slot_q[i] == SLOT_EMPTY) ||
           ((slot_q[i] == SLOT_FULL) && ldData_ready[i]))) begin
        elig_s[i] = 1'b1;
      end else begin
        elig_s[i] = 1'b0;
      end
    end
  end

  // Fixed-priority pick of the lowest eligible port; nothing is granted in reset.
  always_comb begin
    grant_s      = '0;
    grant_addr_s = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      if (rst && elig_s[i] && (grant_s == '0)) begin
        grant_s[i]   = 1'b1;
        grant_addr_s = ldAddr[i*ADDR_TYPE +: ADDR_TYPE];
      end else begin
        grant_s[i] = grant_s[i];
      end
    end
  end

  // Slot next state: grant wins over drain, PEND always lands in FULL.
  always_comb begin
    for (int i = 0; i < NUM_LOADS; i++) begin
      slot_d[i] = slot_q[i];
      data_d[i] = data_q[i];
      if (grant_s[i]) begin
        slot_d[i] = SLOT_PEND;
      end else if (slot_q[i] == SLOT_PEND) begin
        slot_d[i] = SLOT_FULL;
        data_d[i] = loadData;
      end else if ((slot_q[i] == SLOT_FULL) && ldData_ready[i]) begin
        slot_d[i] = SLOT_EMPTY;
      end else begin
        slot_d[i] = slot_q[i];
      end
    end
  end

  // Slot and response-data registers; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LOADS; i++) begin
        slot_q[i] <= SLOT_EMPTY;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LOADS; i++) begin
        slot_q[i] <= slot_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Quiescence: no slot occupied and no port still asking.
  always_comb begin
    all_empty_s = 1'b1;
    for (int i = 0; i < NUM_LOADS; i++) begin
      if (slot_q[i] != SLOT_EMPTY) begin
        all_empty_s = 1'b0;
      end else begin
        all_empty_s = all_empty_s;
      end
    end
    all_done_s = all_empty_s && (ldAddr_valid == '0);
  end

  // Control FSM with registered channel flags; loads are served in any state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q      <= CTRL_IDLE;
      start_rdy_q <= 1'b1;
      end_vld_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      case (ctrl_q)
        CTRL_IDLE: begin
          if (memStart_valid) begin
            ctrl_q      <= CTRL_RUN;
            start_rdy_q <= 1'b0;
            run_q       <= 1'b1;
          end else begin
            ctrl_q <= CTRL_IDLE;
          end
        end
        CTRL_RUN: begin
          if (ctrlEnd_valid && all_done_s) begin
            ctrl_q    <= CTRL_END;
            run_q     <= 1'b0;
            end_vld_q <= 1'b1;
          end else begin
            ctrl_q <= CTRL_RUN;
          end
        end
        CTRL_END: begin
          if (memEnd_ready) begin
            ctrl_q      <= CTRL_IDLE;
            end_vld_q   <= 1'b0;
            start_rdy_q <= 1'b1;
          end else begin
            ctrl_q <= CTRL_END;
          end
        end
        default: begin
          ctrl_q      <= CTRL_IDLE;
          start_rdy_q <= 1'b1;
          end_vld_q   <= 1'b0;
          run_q       <= 1'b0;
        end
      endcase
    end
  end

  assign memStart_ready = start_rdy_q;
  assign memEnd_valid   = end_vld_q;
  assign ctrlEnd_ready  = rst && run_q && all_done_s;

  assign ldAddr_ready = grant_s;
  assign loadEn       = |grant_s;
  assign loadAddr     = grant_addr_s;

  for (genvar gi = 0; gi < NUM_LOADS; gi++) begin : g_port
    assign ldData_valid[gi]                     = (slot_q[gi] == SLOT_FULL);
    assign ldData[gi*DATA_TYPE +: DATA_TYPE]    = data_q[gi];
  end

  assign storeEn   = 1'b0;
  assign storeAddr = '0;
  assign storeData = '0;

endmodule
